// File: rtl/mdu_defs.sv
// Shared definitions for the multiply/divide unit and the EX controller that drives it:
// operation codes, HI/LO read-select encodings and default latencies.
package mdu_defs;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam logic HILO_SEL_HI = 1'b0;
  localparam logic HILO_SEL_LO = 1'b1;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic int mdu_max(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// EX-stage multi-cycle multiply/divide responder owning the architectural HI/LO registers.
// The result is computed at acceptance and committed when the busy counter expires.
module mult_div_unit
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HILOSel,
  output logic        Busy,
  output logic [31:0] HILO
);

  localparam int CW = $clog2(mdu_max(MULT_CYCLES, DIV_CYCLES) + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

  logic [31:0]   hi_r;
  logic [31:0]   lo_r;
  logic [31:0]   pend_hi_r;
  logic [31:0]   pend_lo_r;
  logic          pend_wr_r;
  logic [CW-1:0] cnt_r;
  logic          busy_r;

  md_op_e        op_s;
  logic          accept_s;
  logic          mul_signed_s;
  logic          div_signed_s;
  logic [63:0]   mul_a_s;
  logic [63:0]   mul_b_s;
  logic [63:0]   prod_s;
  logic [31:0]   abs_a_s;
  logic [31:0]   abs_b_s;
  logic [31:0]   divisor_s;
  logic [31:0]   uq_s;
  logic [31:0]   ur_s;
  logic [31:0]   quot_s;
  logic [31:0]   rem_s;

  // Operation decode and single-cycle product/quotient from the accepted operands.
  always_comb begin
    op_s         = md_op_e'(MDOp);
    accept_s     = Start & ~busy_r;
    mul_signed_s = (op_s == MD_MULT);
    div_signed_s = (op_s == MD_DIV);
    mul_a_s      = mul_signed_s ? {{32{A[31]}}, A} : {32'd0, A};
    mul_b_s      = mul_signed_s ? {{32{B[31]}}, B} : {32'd0, B};
    prod_s       = mul_a_s * mul_b_s;
    // Signed division runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    abs_a_s      = (div_signed_s && A[31]) ? (32'd0 - A) : A;
    abs_b_s      = (div_signed_s && B[31]) ? (32'd0 - B) : B;
    // A zero divisor is swapped for 1 so the divider stays defined; its result is never committed.
    divisor_s    = (abs_b_s == 32'd0) ? 32'd1 : abs_b_s;
    uq_s         = abs_a_s / divisor_s;
    ur_s         = abs_a_s % divisor_s;
    quot_s       = (div_signed_s && (A[31] ^ B[31])) ? (32'd0 - uq_s) : uq_s;
    rem_s        = (div_signed_s && A[31]) ? (32'd0 - ur_s) : ur_s;
  end

  // HI/LO, pending result and busy counter; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_wr_r <= 1'b0;
      cnt_r     <= CNT_ZERO;
      busy_r    <= 1'b0;
    end else if (accept_s) begin
      case (op_s)
        MD_MULT, MD_MULTU: begin
          pend_hi_r <= prod_s[63:32];
          pend_lo_r <= prod_s[31:0];
          pend_wr_r <= 1'b1;
          cnt_r     <= MULT_LOAD;
          busy_r    <= 1'b1;
        end
        MD_DIV, MD_DIVU: begin
          pend_hi_r <= rem_s;
          pend_lo_r <= quot_s;
          pend_wr_r <= (B != 32'd0);
          cnt_r     <= DIV_LOAD;
          busy_r    <= 1'b1;
        end
        MD_MTHI: hi_r <= A;
        MD_MTLO: lo_r <= A;
        default: begin
          hi_r <= hi_r;
        end
      endcase
    end else if (busy_r) begin
      cnt_r <= (cnt_r != CNT_ZERO) ? (cnt_r - CNT_ONE) : CNT_ZERO;
      if (cnt_r <= CNT_ONE) begin
        busy_r <= 1'b0;
        if (pend_wr_r) begin
          hi_r <= pend_hi_r;
          lo_r <= pend_lo_r;
        end else begin
          hi_r <= hi_r;
        end
      end else begin
        busy_r <= 1'b1;
      end
    end else begin
      busy_r <= 1'b0;
    end
  end

  assign Busy = busy_r;
  assign HILO = (HILOSel == HILO_SEL_LO) ? lo_r : hi_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases followed by randomized operations,
// all checked against an arithmetic reference model of HI/LO and the busy window length.
module tb_mult_div_unit;
  import mdu_defs::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        HILOSel;
  logic        Busy;
  logic [31:0] HILO;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] ref_hi;
  logic [31:0] ref_lo;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .HILOSel(HILOSel), .Busy(Busy), .HILO(HILO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: architectural effect of one accepted operation on HI/LO.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sb; ref_hi = p[63:32]; ref_lo = p[31:0]; end
      3'd1: begin up = ua * ub; ref_hi = up[63:32]; ref_lo = up[31:0]; end
      3'd2: if (b != 32'd0) begin
        q = sa / sb; r = sa % sb; ref_lo = q[31:0]; ref_hi = r[31:0];
      end
      3'd3: if (b != 32'd0) begin ref_lo = a / b; ref_hi = a % b; end
      3'd4: ref_hi = a;
      3'd5: ref_lo = a;
      default: ;
    endcase
  endtask

  // Called in the low clock phase; returns at a negedge.
  task automatic read_hilo(input string tag);
    HILOSel = 1'b0;
    #1 check({tag, " HI"}, HILO, ref_hi);
    HILOSel = 1'b1;
    #1 check({tag, " LO"}, HILO, ref_lo);
    check({tag, " busy-idle"}, {31'd0, Busy}, 32'd0);
    @(negedge clk);
  endtask

  // Drives a one-cycle Start, then scrambles operands so late changes would be visible.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start   = 1'b1;
    MDOp    = op;
    A       = a;
    B       = b;
    HILOSel = 1'($urandom_range(0, 1));
    @(negedge clk);
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    issue(op, a, b);
    if (op <= 3'd3) begin
      check({tag, " hilo-old"}, HILO, HILOSel ? ref_lo : ref_hi);
      n = 0;
      while (Busy === 1'b1 && n < 64) begin
        n++;
        @(negedge clk);
      end
      check({tag, " busy-cycles"}, 32'(n), (op <= 3'd1) ? 32'(MULT_N) : 32'(DIV_N));
    end else begin
      check({tag, " no-busy"}, {31'd0, Busy}, 32'd0);
    end
    model(op, a, b);
    read_hilo(tag);
  endtask

  initial begin
    int          n;
    logic [2:0]  op;
    logic [31:0] ra, rb;

    reset = 1'b1; Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0; HILOSel = 1'b0;
    ref_hi = 32'd0; ref_lo = 32'd0;
    repeat (2) @(negedge clk);
    read_hilo("reset");
    reset = 1'b0;

    run_op("mthi", 3'd4, 32'h12345678, 32'h0);
    run_op("mtlo", 3'd5, 32'h9ABCDEF0, 32'h0);
    run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3);
    run_op("multu", 3'd1, 32'hFFFFFFFE, 32'd3);
    run_op("div-neg", 3'd2, 32'hFFFFFFF9, 32'd2);
    run_op("divu", 3'd3, 32'd7, 32'd2);
    run_op("div-ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_op("mthi11", 3'd4, 32'h11, 32'h0);
    run_op("mtlo22", 3'd5, 32'h22, 32'h0);
    run_op("divu-zero", 3'd3, 32'h55, 32'd0);
    run_op("div-zero", 3'd2, 32'h80000000, 32'd0);

    // Starts while busy (including the final busy cycle) must be ignored.
    ra = $urandom; rb = $urandom;
    issue(3'd0, ra, rb);
    n = 0;
    while (Busy === 1'b1 && n < 64) begin
      n++;
      Start = 1'b1;
      MDOp  = n[0] ? 3'd2 : 3'd4;
      A     = $urandom;
      B     = $urandom;
      @(negedge clk);
    end
    Start = 1'b0;
    check("busy-ignore cycles", 32'(n), 32'(MULT_N));
    model(3'd0, ra, rb);
    HILOSel = 1'b0;
    #1 check("busy-ignore HI", HILO, ref_hi);
    HILOSel = 1'b1;
    #1 check("busy-ignore LO", HILO, ref_lo);
    run_op("div-after-fall", 3'd2, $urandom, 32'd7);

    // Reset during busy cycle 3 of a divide: everything clears, nothing commits later.
    run_op("mthi11b", 3'd4, 32'h11, 32'h0);
    issue(3'd2, 32'h1000, 32'd3);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_hi = 32'd0; ref_lo = 32'd0;
    check("reset-mid busy", {31'd0, Busy}, 32'd0);
    repeat (DIV_N + 2) @(negedge clk);
    read_hilo("reset-mid no-commit");

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      run_op("random", op, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide responder in the EX stage. Answers the Start/Busy handshake driven by the EX controller and owns the architectural HI/LO registers.
- Executes mult, multu, div, divu, mthi and mtlo.
- Presents HI or LO on a read port for mfhi/mflo, which the EX result mux forwards into the EX/MEM register.
- The hazard unit stalls on Busy, or on Start of a mult/div.

Parameters:
- MULT_CYCLES, 5, Busy-high cycles for mult/multu (>=1).
- DIV_CYCLES, 10, Busy-high cycles for div/divu (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle request; qualifies MDOp, A, B.
- MDOp  input  3  operation code; see Behaviour.
- A  input  32  rs operand, after forwarding.
- B  input  32  rt operand, after forwarding.
- HILOSel  input  1  read select: 0 = HI, 1 = LO.
- Busy  output  1  an operation is in flight.
- HILO  output  32  selected HI or LO register, combinational from registers.

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high. On a reset edge, HI, LO, the pending registers and the counter clear, and Busy is 0. Reset takes priority over everything, including an in-flight operation, which is discarded with no commit.
- MDOp encoding: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO. Codes 6 and 7 are no-ops.
- Start is accepted only at an edge where Busy==0 and reset==0. A Start seen while Busy==1 is ignored entirely: no state change, no queuing.
- MTHI/MTLO: HI (or LO) <= A at the accepting edge. Busy stays 0. New value is visible on HILO the next cycle.
- MULT/MULTU, accepted at edge k:
  - The 64-bit product {HI,LO} = A*B is computed at edge k (signed or unsigned) and captured into PendHI/PendLO.
  - The counter loads MULT_CYCLES and Busy goes 1 after edge k.
  - The counter decrements each edge. At edge k+MULT_CYCLES, HI/LO <= Pend and Busy goes 0 at the same edge.
  - Busy is therefore high exactly MULT_CYCLES cycles.
- DIV/DIVU: same flow with DIV_CYCLES. LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
- Divide by zero (B==0, div or divu): Busy still runs DIV_CYCLES cycles. HI and LO are left unchanged at completion.
- HILO = HILOSel ? LO : HI at all times. While Busy, it shows the pre-operation values; new values appear in the cycle after Busy falls.
- Start in the same cycle Busy falls (Busy==1 sampled) is ignored. Start in the cycle after Busy falls is accepted normally.
- Operands A and B are sampled only at acceptance. Later changes to A/B have no effect.
- Counter width is clog2(max(MULT_CYCLES, DIV_CYCLES)+1). It never wraps: the decrement stops at 0.

Decomposition:
- Shared package mdu_defs holds:
  - MDOp codes (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
  - the HILOSel encodings;
  - default latencies.
- The EX controller imports the same package to produce MDOp and HILOSel.
- No sub-module: arithmetic and counter are inline, in one file of about 150–250 lines.

Test Plan:
- Reset, then read: HILOSel=0 and HILOSel=1 both give HILO=0, Busy=0. MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 → HI=0x12345678, LO=0x9ABCDEF0, Busy never asserted.
- MULT A=0xFFFFFFFE, B=3 → Busy high exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA after fall. HILO shows old values while Busy. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 → Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 → LO=3, HI=1. DIV 0x80000000 by 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU with B=0 after HI=0x11, LO=0x22 → Busy 10 cycles, then HI=0x11, LO=0x22 unchanged.
- During a MULT busy window: issue Start DIV and Start MTHI, and change A/B → all ignored; the original product commits unchanged. Start DIV in the cycle after Busy falls is accepted.
- Assert reset at busy cycle 3 of a DIV that follows HI=0x11 → Busy=0, HI=LO=0 next cycle; no late commit occurs.
